range_counter: RTL and testbench

Parametrised bounded counter. It counts up or down by a configurable step between programmable limits MIN and MAX, and supports wrap or saturate at the limits, range-checked parallel load, and count enable. Registered terminal-count and load-error flags let it serve as the shared sequencing and timing primitive for the sequential-logic library, replacing fixed-range one-off counters.

---
 rtl/counter_pkg.sv | 17 +
 rtl/range_cnt_next.sv | 51 +++++
 rtl/range_counter.sv | 79 +++++++
 tb/tb_range_counter.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared constants and helpers for the bounded counter family
package counter_pkg;

    localparam logic DIR_UP    = 1'b1;
    localparam logic DIR_DN    = 1'b0;
    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

    function automatic logic in_range(
        input int unsigned val,
        input int unsigned min,
        input int unsigned max
    );
        return (val >= min) && (val <= max);
    endfunction

endpackage

// File: rtl/range_cnt_next.sv
// rtl/range_cnt_next.sv - combinational next-count and limit-hit computation for one channel
module range_cnt_next
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned MIN   = 3,
    parameter int unsigned MAX   = 12,
    parameter int unsigned STEP  = 1
) (
    input  logic [WIDTH-1:0] count,
    input  logic             up_dn,
    input  logic             sat,
    output logic [WIDTH-1:0] next_count,
    output logic             hit
);

    localparam logic [WIDTH-1:0] MIN_N   = WIDTH'(MIN);
    localparam logic [WIDTH-1:0] MAX_N   = WIDTH'(MAX);
    localparam logic [WIDTH-1:0] STEP_N  = WIDTH'(STEP);
    localparam logic [WIDTH:0]   STEP_W  = (WIDTH+1)'(STEP);
    localparam logic [WIDTH:0]   MAX_W   = (WIDTH+1)'(MAX);
    localparam logic [WIDTH:0]   FLOOR_W = (WIDTH+1)'(MIN + STEP);

    // One extra bit so count+STEP near the top of the range cannot overflow.
    logic [WIDTH:0] w_cnt_ext;
    logic [WIDTH:0] w_sum;

    assign w_cnt_ext = {1'b0, count};
    assign w_sum     = w_cnt_ext + STEP_W;

    always_comb begin
        next_count = count;
        hit        = 1'b0;
        if (up_dn == DIR_UP) begin
            if (w_sum <= MAX_W) begin
                next_count = w_sum[WIDTH-1:0];
            end else begin
                next_count = (sat == MODE_SAT) ? MAX_N : MIN_N;
                hit        = 1'b1;
            end
        end else begin
            if (w_cnt_ext >= FLOOR_W) begin
                next_count = count - STEP_N;
            end else begin
                next_count = (sat == MODE_SAT) ? MIN_N : MAX_N;
                hit        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/range_counter.sv
// rtl/range_counter.sv - bounded up/down counter with wrap/saturate, checked load and flags
module range_counter
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned MIN   = 3,
    parameter int unsigned MAX   = 12,
    parameter int unsigned STEP  = 1
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             up_dn,
    input  logic             sat,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             load_err
);

    if (!(MIN < MAX && MAX <= (1 << WIDTH) - 1 && STEP >= 1 && STEP <= MAX - MIN)) begin : g_bad_params
        $fatal(1, "range_counter: illegal MIN/MAX/STEP/WIDTH combination");
    end

    localparam logic [WIDTH-1:0] MIN_N = WIDTH'(MIN);

    logic [WIDTH-1:0] r_count;
    logic             r_tc;
    logic             r_load_err;
    logic [WIDTH-1:0] w_next;
    logic             w_hit;

    range_cnt_next #(
        .WIDTH (WIDTH),
        .MIN   (MIN),
        .MAX   (MAX),
        .STEP  (STEP)
    ) u_next (
        .count      (r_count),
        .up_dn      (up_dn),
        .sat        (sat),
        .next_count (w_next),
        .hit        (w_hit)
    );

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            r_count    <= MIN_N;
            r_tc       <= 1'b0;
            r_load_err <= 1'b0;
        end else if (load) begin
            if (in_range(32'(din), MIN, MAX)) begin
                r_count    <= din;
                r_load_err <= 1'b0;
            end else begin
                r_load_err <= 1'b1;
            end
            r_tc <= 1'b0;
        end else if (!in_range(32'(r_count), MIN, MAX)) begin
            // Recover from an illegal count (e.g. power-up without clear) on any non-load cycle.
            r_count    <= MIN_N;
            r_tc       <= 1'b0;
            r_load_err <= 1'b0;
        end else if (en) begin
            r_count    <= w_next;
            r_tc       <= w_hit;
            r_load_err <= 1'b0;
        end else begin
            r_tc       <= 1'b0;
            r_load_err <= 1'b0;
        end
    end

    assign count    = r_count;
    assign tc       = r_tc;
    assign load_err = r_load_err;

endmodule

// File: tb/tb_range_counter.sv
// tb/tb_range_counter.sv - scoreboard bench for range_counter with STEP=1 and STEP=4 instances
module tb_range_counter;

    localparam int MIN = 3;
    localparam int MAX = 12;

    typedef struct {
        int   cyc;
        logic [3:0] c;
        logic tc;
        logic err;
    } exp_t;

    logic       clk = 1'b0;
    logic       clr_n = 1'b0;
    logic       en = 1'b0;
    logic       load = 1'b0;
    logic [3:0] din = 4'd0;
    logic       up_dn = 1'b1;
    logic       sat = 1'b0;
    logic [3:0] count1, count4;
    logic       tc1, tc4, err1, err4;

    exp_t q1[$];
    exp_t q4[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   m1 = MIN;
    int   m4 = MIN;

    always #5 clk = ~clk;

    range_counter #(.WIDTH(4), .MIN(3), .MAX(12), .STEP(1)) dut1 (
        .clk(clk), .clr_n(clr_n), .en(en), .load(load), .din(din),
        .up_dn(up_dn), .sat(sat), .count(count1), .tc(tc1), .load_err(err1)
    );

    range_counter #(.WIDTH(4), .MIN(3), .MAX(12), .STEP(4)) dut4 (
        .clk(clk), .clr_n(clr_n), .en(en), .load(load), .din(din),
        .up_dn(up_dn), .sat(sat), .count(count4), .tc(tc4), .load_err(err4)
    );

    function automatic exp_t model(input int step, inout int c);
        exp_t e;
        e.tc  = 1'b0;
        e.err = 1'b0;
        if (!clr_n) begin
            c = MIN;
        end else if (load) begin
            if (int'(din) >= MIN && int'(din) <= MAX) c = int'(din);
            else e.err = 1'b1;
        end else if (en) begin
            if (up_dn) begin
                if (c + step > MAX) begin
                    c    = sat ? MAX : MIN;
                    e.tc = 1'b1;
                end else begin
                    c = c + step;
                end
            end else begin
                if (c - step < MIN) begin
                    c    = sat ? MIN : MAX;
                    e.tc = 1'b1;
                end else begin
                    c = c - step;
                end
            end
        end
        e.c   = 4'(c);
        e.cyc = cyc;
        return e;
    endfunction

    task automatic drive(input logic r, input logic ld, input logic [3:0] d,
                         input logic e, input logic u, input logic s);
        @(negedge clk);
        clr_n = r;
        load  = ld;
        din   = d;
        en    = e;
        up_dn = u;
        sat   = s;
        cyc++;
        q1.push_back(model(1, m1));
        q4.push_back(model(4, m4));
    endtask

    task automatic compare(input string name, input exp_t e,
                           input logic [3:0] c, input logic t, input logic le);
        checks++;
        if (c !== e.c || t !== e.tc || le !== e.err) begin
            errors++;
            $display("FAIL %s cyc=%0d: count=%0d tc=%0b load_err=%0b, expected count=%0d tc=%0b load_err=%0b",
                     name, e.cyc, c, t, le, e.c, e.tc, e.err);
        end
    endtask

    initial begin : monitor
        forever begin
            @(posedge clk);
            #1;
            if (q1.size() > 0) compare("step1", q1.pop_front(), count1, tc1, err1);
            if (q4.size() > 0) compare("step4", q4.pop_front(), count4, tc4, err4);
        end
    end

    initial begin : stimulus
        // Reset overrides load and enable.
        repeat (2) drive(1'b0, 1'b1, 4'd9, 1'b1, 1'b1, 1'b0);
        repeat (10) drive(1'b1, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0);
        // Saturate at MAX, then step down.
        drive(1'b1, 1'b1, 4'd12, 1'b0, 1'b1, 1'b0);
        repeat (3) drive(1'b1, 1'b0, 4'd0, 1'b1, 1'b1, 1'b1);
        drive(1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1);
        // Wrap down from MIN.
        drive(1'b1, 1'b1, 4'd3, 1'b0, 1'b1, 1'b0);
        repeat (2) drive(1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
        // Load range checks and load-over-enable priority.
        drive(1'b1, 1'b1, 4'd13, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 4'd2, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 4'd7, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 4'd5, 1'b1, 1'b1, 1'b0);
        // Near-top step: wrap, then saturate.
        drive(1'b1, 1'b1, 4'd11, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 4'd11, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 4'd0, 1'b1, 1'b1, 1'b1);
        // Mid-count clear then idle.
        drive(1'b1, 1'b1, 4'd8, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0);
        repeat (5) drive(1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 31) != 0), ($urandom_range(0, 7) == 0),
                  4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0),
                  1'($urandom), 1'($urandom));
        end
        drive(1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (q1.size() != 0 || q4.size() != 0) begin
            errors++;
            $display("FAIL drain: pending=%0d/%0d, expected 0/0", q1.size(), q4.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
